// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state enum, the IF/ID payload struct, the NOP
// encoding used for bubbles and the PC / instruction widths.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instr:    NOP_WORD,
        pc:       '0,
        pc_plus1: '0,
        valid:    1'b0
    };

endpackage

// File: rtl/pc_register.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst          - clock, async active-high reset (loads RESET_PC)
//   i_redirect        - load i_redirect_pc (highest priority)
//   i_redirect_pc     - redirect target, word index
//   i_hold            - keep the current PC when not redirecting
//   o_pc              - registered PC (word index)
//   o_pc_plus1_c      - combinational PC+1, wraps modulo 2^32
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_hold,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus1_c
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_plus1;

    // Increment wraps naturally at the register width
    assign w_pc_plus1 = r_pc + PC_W'(1);

    // Next-PC mux: redirect, then hold, else sequential
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = i_redirect_pc;
        end else if (!i_hold) begin
            w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus1_c = w_pc_plus1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALT FSM and the IF/ID register.
// Ports:
//   clk, rst        - clock, async active-high reset
//   stall           - hold PC and IF/ID
//   redirect        - taken branch/jump; load redirect_pc, bubble IF/ID
//   redirect_pc     - redirect target (word index)
//   imem_addr       - word address to instruction memory (equals PC)
//   imem_data       - combinational instruction memory read data
//   ifid_instr/pc/pc_plus1/valid - IF/ID register contents
//   halted          - FSM is in HALT
//   perf_fetch_cnt, perf_stall_cnt - saturating counters, present only
//                     when FETCH_PERF_CNT_EN is defined
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic               ifid_valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    ifid_t           r_ifid;
    ifid_t           w_ifid_nxt;
    logic            w_pc_redirect;
    logic            w_pc_hold;
    logic            w_fetch;
    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] w_pc_plus1;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (w_pc_redirect),
        .i_redirect_pc (redirect_pc),
        .i_hold        (w_pc_hold),
        .o_pc          (w_pc),
        .o_pc_plus1_c  (w_pc_plus1)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, PC control and IF/ID next value
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_redirect = 1'b0;
        w_pc_hold     = 1'b1;
        w_ifid_nxt    = r_ifid;
        w_fetch       = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect) begin
                    // Redirect beats stall and any HALT_WORD on the bus
                    w_pc_redirect = 1'b1;
                    w_ifid_nxt    = IFID_BUBBLE;
                end else if (!stall) begin
                    w_pc_hold           = 1'b0;
                    w_fetch             = 1'b1;
                    w_ifid_nxt.instr    = imem_data;
                    w_ifid_nxt.pc       = w_pc;
                    w_ifid_nxt.pc_plus1 = w_pc_plus1;
                    w_ifid_nxt.valid    = 1'b1;
                    if (imem_data == HALT_WORD) begin
                        w_state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    w_state_nxt   = RUN;
                    w_pc_redirect = 1'b1;
                    w_ifid_nxt    = IFID_BUBBLE;
                end else if (!stall) begin
                    w_ifid_nxt = IFID_BUBBLE;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid <= IFID_BUBBLE;
        end else begin
            r_ifid <= w_ifid_nxt;
        end
    end

    assign imem_addr     = w_pc;
    assign ifid_instr    = r_ifid.instr;
    assign ifid_pc       = r_ifid.pc;
    assign ifid_pc_plus1 = r_ifid.pc_plus1;
    assign ifid_valid    = r_ifid.valid;
    assign halted        = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Saturating fetch and stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_fetch && (r_perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'(1);
            end
            if (stall && !redirect && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'(1);
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes the
// expected IF/ID / PC / halted state each cycle, popped after the edge.
module tb_fetch_stage;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[5:0]];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc1;
        logic [31:0] addr;
        logic        valid;
        logic        halted;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc1, m_fcnt, m_scnt;
    logic        m_valid, m_halt;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc1 = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_ipc = 32'h0; m_ipc1 = 32'h0; m_valid = 1'b0;
    endtask

    // one clock: drive inputs, predict, push, clock, pop and compare
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        exp_t        e;
        logic [31:0] d;
        stall = s; redirect = r; redirect_pc = rpc;
        d = mem[m_pc[5:0]];
        if (r) begin
            m_pc = rpc; m_halt = 1'b0; model_bubble();
        end else if (s) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        end else if (m_halt) begin
            model_bubble();
        end else begin
            m_instr = d; m_ipc = m_pc; m_ipc1 = m_pc + 1; m_valid = 1'b1;
            if (d == HALT_W) m_halt = 1'b1;
            m_pc = m_pc + 1;
            if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end
        sb.push_back('{instr: m_instr, pc: m_ipc, pc1: m_ipc1, addr: m_pc,
                       valid: m_valid, halted: m_halt, fcnt: m_fcnt, scnt: m_scnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests += 6;
        if (ifid_instr !== e.instr) begin fails++; $display("FAIL step ifid_instr got %h want %h", ifid_instr, e.instr); end
        if (ifid_pc !== e.pc) begin fails++; $display("FAIL step ifid_pc got %h want %h", ifid_pc, e.pc); end
        if (ifid_pc_plus1 !== e.pc1) begin fails++; $display("FAIL step ifid_pc_plus1 got %h want %h", ifid_pc_plus1, e.pc1); end
        if (imem_addr !== e.addr) begin fails++; $display("FAIL step imem_addr got %h want %h", imem_addr, e.addr); end
        if (ifid_valid !== e.valid) begin fails++; $display("FAIL step ifid_valid got %b want %b", ifid_valid, e.valid); end
        if (halted !== e.halted) begin fails++; $display("FAIL step halted got %b want %b", halted, e.halted); end
`ifdef FETCH_PERF_CNT_EN
        tests += 2;
        if (perf_fetch_cnt !== e.fcnt) begin fails++; $display("FAIL step perf_fetch_cnt got %0d want %0d", perf_fetch_cnt, e.fcnt); end
        if (perf_stall_cnt !== e.scnt) begin fails++; $display("FAIL step perf_stall_cnt got %0d want %0d", perf_stall_cnt, e.scnt); end
`endif
    endtask

    task automatic mem_init();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #2;
        tests += 5;
        if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset imem_addr got %h want 0", imem_addr); end
        if (ifid_instr !== 32'h0) begin fails++; $display("FAIL reset ifid_instr got %h want 0", ifid_instr); end
        if (ifid_pc_plus1 !== 32'h0) begin fails++; $display("FAIL reset ifid_pc_plus1 got %h want 0", ifid_pc_plus1); end
        if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset ifid_valid got %b want 0", ifid_valid); end
        if (halted !== 1'b0) begin fails++; $display("FAIL reset halted got %b want 0", halted); end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] want [4];
        want[0] = 32'd11; want[1] = 32'd22; want[2] = 32'd33; want[3] = 32'd44;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            tests += 2;
            if (ifid_instr !== want[k]) begin fails++; $display("FAIL seq instr%0d got %0d want %0d", k, ifid_instr, want[k]); end
            if (ifid_pc !== 32'(k)) begin fails++; $display("FAIL seq pc%0d got %0d want %0d", k, ifid_pc, k); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 32'h0);
            tests += 2;
            if (ifid_instr !== 32'd22) begin fails++; $display("FAIL stall instr got %0d want 22", ifid_instr); end
            if (imem_addr !== 32'd2) begin fails++; $display("FAIL stall addr got %0d want 2", imem_addr); end
        end
        step(1'b0, 1'b0, 32'h0);
        tests++;
        if (ifid_instr !== 32'd33) begin fails++; $display("FAIL stall resume got %0d want 33", ifid_instr); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'd8);
        tests += 2;
        if (ifid_valid !== 1'b0) begin fails++; $display("FAIL redir valid got %b want 0", ifid_valid); end
        if (imem_addr !== 32'd8) begin fails++; $display("FAIL redir addr got %0d want 8", imem_addr); end
        step(1'b0, 1'b0, 32'h0);
        tests++;
        if (ifid_pc !== 32'd8) begin fails++; $display("FAIL redir pc got %0d want 8", ifid_pc); end
    endtask

    task automatic test_halt();
        mem[2] = HALT_W;
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0);
        tests += 4;
        if (ifid_instr !== HALT_W) begin fails++; $display("FAIL halt instr got %h want %h", ifid_instr, HALT_W); end
        if (ifid_valid !== 1'b1) begin fails++; $display("FAIL halt valid got %b want 1", ifid_valid); end
        if (halted !== 1'b1) begin fails++; $display("FAIL halt halted got %b want 1", halted); end
        if (imem_addr !== 32'd3) begin fails++; $display("FAIL halt addr got %0d want 3", imem_addr); end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests++;
        if (ifid_valid !== 1'b0) begin fails++; $display("FAIL halt bubble valid got %b want 0", ifid_valid); end
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        tests++;
        if (halted !== 1'b0) begin fails++; $display("FAIL halt exit halted got %b want 0", halted); end
        step(1'b0, 1'b0, 32'h0);
        tests++;
        if (ifid_instr !== 32'd11) begin fails++; $display("FAIL halt restart got %0d want 11", ifid_instr); end
        mem[2] = 32'd33;
    endtask

    task automatic test_redirect_beats_halt();
        mem[2] = HALT_W;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'd5);
        tests++;
        if (halted !== 1'b0) begin fails++; $display("FAIL conflict halted got %b want 0", halted); end
        step(1'b0, 1'b0, 32'h0);
        mem[2] = 32'd33;
    endtask

    task automatic test_redirect_stall_and_async_reset();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'd20);
        tests += 2;
        if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rs valid got %b want 0", ifid_valid); end
        if (imem_addr !== 32'd20) begin fails++; $display("FAIL rs addr got %0d want 20", imem_addr); end
        step(1'b0, 1'b0, 32'h0);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd40;
        #2;
        rst = 1'b1;
        #1;
        tests += 4;
        if (imem_addr !== 32'h0) begin fails++; $display("FAIL arst addr got %h want 0", imem_addr); end
        if (ifid_instr !== 32'h0) begin fails++; $display("FAIL arst instr got %h want 0", ifid_instr); end
        if (ifid_pc !== 32'h0) begin fails++; $display("FAIL arst pc got %h want 0", ifid_pc); end
        if (ifid_valid !== 1'b0) begin fails++; $display("FAIL arst valid got %b want 0", ifid_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 32'h0);
        tests++;
        if (ifid_pc !== 32'h0) begin fails++; $display("FAIL arst first fetch pc got %h want 0", ifid_pc); end
    endtask

    task automatic test_wrap();
        mem[63] = 32'h0000_1234;
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'h0);
        tests += 2;
        if (ifid_pc_plus1 !== 32'h0) begin fails++; $display("FAIL wrap pc_plus1 got %h want 0", ifid_pc_plus1); end
        if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap addr got %h want 0", imem_addr); end
        step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 4; i < 64; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? HALT_W : $urandom;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 32'($urandom_range(0, 63)));
        end
        mem_init();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        tests += 2;
        if (perf_fetch_cnt !== 32'd5) begin fails++; $display("FAIL perf fetch got %0d want 5", perf_fetch_cnt); end
        if (perf_stall_cnt !== 32'd2) begin fails++; $display("FAIL perf stall got %0d want 2", perf_stall_cnt); end
    endtask
`endif

    initial begin
        mem_init();
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_redirect_beats_halt();
        test_redirect_stall_and_async_reset();
        test_wrap();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000: word index loaded into the PC on reset.
REQ-002 The block SHALL take parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that halts fetch.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the PC and the IF/ID register.
REQ-006 The block SHALL have port redirect, input, 1 bit: a branch or jump is taken; load redirect_pc.
REQ-007 The block SHALL have port redirect_pc, input, 32 bits: redirect target, as a word index.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: word address to the instruction memory.
REQ-009 The block SHALL have port imem_data, input, 32 bits: the combinational read of the instruction memory at imem_addr.
REQ-010 The block SHALL have port ifid_instr, output, 32 bits: the registered instruction.
REQ-011 The block SHALL have port ifid_pc, output, 32 bits: the PC of ifid_instr.
REQ-012 The block SHALL have port ifid_pc_plus1, output, 32 bits: ifid_pc+1.
REQ-013 The block SHALL have port ifid_valid, output, 1 bit: ifid_instr is a real instruction and not a bubble.
REQ-014 The block SHALL have port halted, output, 1 bit: the FSM is in state HALT.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally, with no added latency; the PC counts words (+1 per instruction).
REQ-016 The FSM SHALL have exactly two states, RUN and HALT; halted SHALL be 1 only in HALT.
REQ-017 In RUN with redirect=1, each edge SHALL set PC<=redirect_pc, ifid_instr<=0, ifid_pc<=0, ifid_pc_plus1<=0 and ifid_valid<=0, regardless of stall.
REQ-018 In RUN with redirect=0 and stall=1, the PC and all ifid_* outputs SHALL hold their values.
REQ-019 In RUN with redirect=0 and stall=0, each edge SHALL set ifid_instr<=imem_data, ifid_pc<=PC, ifid_pc_plus1<=PC+1, ifid_valid<=1 and PC<=PC+1.
REQ-020 Fetch latency SHALL be one cycle from the PC value to the matching ifid_instr.
REQ-021 If a captured imem_data equals HALT_WORD, the FSM SHALL go to HALT on the same edge; that instruction SHALL still appear with ifid_valid=1, and the PC SHALL freeze at its address +1.
REQ-022 In HALT with redirect=0, the PC SHALL hold; with stall=0 the IF/ID SHALL load a bubble (all zero, valid 0); with stall=1 the IF/ID SHALL hold.
REQ-023 In HALT with redirect=1, the FSM SHALL return to RUN, load PC<=redirect_pc, and load a bubble into IF/ID.
REQ-024 PC+1 SHALL wrap modulo 2^32, so 32'hFFFF_FFFF goes to 0, with no flag raised.
REQ-025 When redirect=1 and a HALT_WORD is on imem_data in the same cycle, redirect SHALL win: no halt, and the FSM stays in RUN.

Reset
REQ-026 While rst=1 the block SHALL asynchronously set PC=RESET_PC, state=RUN, all ifid_*=0, halted=0, and both counters (if present) =0.
REQ-027 Assertion of rst mid-stall, mid-redirect or in HALT SHALL override all other inputs; the first fetch after deassertion SHALL be from RESET_PC.

Configuration
REQ-028 When the macro FETCH_PERF_CNT_EN is defined, the block SHALL add outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
REQ-029 perf_fetch_cnt SHALL increment on each edge that loads ifid_valid<=1.
REQ-030 perf_stall_cnt SHALL increment on each edge with stall=1 and redirect=0.
REQ-031 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-032 When FETCH_PERF_CNT_EN is undefined, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum (RUN, HALT), NOP_WORD=32'h0, and the PC and instruction width constants.
REQ-034 One sub-module, pc_register, SHALL hold the PC with its async reset and next-PC mux (redirect / hold / +1); the FSM and IF/ID register SHALL stay in fetch_stage.

Verification
REQ-035 Sequential fetch: mem[0..3]=11,22,33,44, no stall -> after reset, edges 1..4 give ifid_instr=11,22,33,44, ifid_pc=0..3, valid=1.
REQ-036 Stall: stall=1 for 2 cycles after edge 2 -> ifid_instr stays 22 and imem_addr stays 2, then the sequence resumes with 33.
REQ-037 Redirect: redirect=1 with redirect_pc=8 at PC=3 -> next edge gives ifid_valid=0 and imem_addr=8; the following edge gives ifid_pc=8.
REQ-038 Halt: mem[2]=HALT_WORD -> at edge 3 ifid_instr=HALT_WORD, valid=1, halted=1, imem_addr=3; later edges give valid=0; redirect_pc=0 -> halted=0 and fetch restarts at 0.
REQ-039 Redirect+stall and async reset: redirect=1 with stall=1 -> bubble and PC=target; rst pulsed between edges -> PC=RESET_PC immediately, all ifid_*=0.
REQ-040 With FETCH_PERF_CNT_EN: 5 fetches and 2 stalls -> perf_fetch_cnt=5 and perf_stall_cnt=2.
